// File: rtl/seg_p2s_tx.sv
// Serial transmitter for the 64-bit segment-text frame: shifts MSB first into the
// external register chain on s_clk, then pulses s_pen so all digits update together.
module seg_p2s_tx #(
    parameter int DIV   = 2,
    parameter int NBITS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBITS-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             s_clk,
    output logic             s_dat,
    output logic             s_pen,
    output logic             s_clr
);

    localparam int              DW       = $clog2(DIV) + 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
    localparam logic [5:0]      BIT_LAST = 6'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t           state, state_n;
    logic [NBITS-1:0] sh, sh_n;
    logic [5:0]       bit_cnt, bit_cnt_n;
    logic [DW-1:0]    div_cnt, div_cnt_n;
    logic             busy_n, done_n, s_clk_n, s_dat_n, s_pen_n;
    logic             div_end;

    assign div_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s_clk   <= 1'b0;
            s_dat   <= 1'b0;
            s_pen   <= 1'b0;
            s_clr   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            div_cnt <= div_cnt_n;
            busy    <= busy_n;
            done    <= done_n;
            s_clk   <= s_clk_n;
            s_dat   <= s_dat_n;
            s_pen   <= s_pen_n;
            // Chain clear is released once after reset and then held inactive.
            s_clr   <= 1'b1;
        end
    end

    // Frame shift register carries only data; its content is don't-care outside a frame.
    always_ff @(posedge clk) begin
        sh <= sh_n;
    end

    always_comb begin
        state_n   = state;
        sh_n      = sh;
        bit_cnt_n = bit_cnt;
        div_cnt_n = div_cnt;
        busy_n    = busy;
        done_n    = 1'b0;
        s_clk_n   = s_clk;
        s_dat_n   = s_dat;
        s_pen_n   = s_pen;

        case (state)
            IDLE: begin
                if (start) begin
                    sh_n      = data;
                    s_dat_n   = data[NBITS-1];
                    bit_cnt_n = '0;
                    div_cnt_n = '0;
                    busy_n    = 1'b1;
                    s_clk_n   = 1'b0;
                    state_n   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_end) begin
                    s_clk_n   = 1'b1;
                    div_cnt_n = '0;
                    state_n   = SHIFT_HI;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    s_clk_n   = 1'b0;
                    div_cnt_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        s_pen_n = 1'b1;
                        state_n = LATCH;
                    end else begin
                        // Next bit is presented on the falling edge for full setup time.
                        sh_n      = sh << 1;
                        s_dat_n   = sh[NBITS-2];
                        bit_cnt_n = bit_cnt + 6'd1;
                        state_n   = SHIFT_LO;
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            LATCH: begin
                if (div_end) begin
                    div_cnt_n = '0;
                    s_pen_n   = 1'b0;
                    s_dat_n   = 1'b0;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                    state_n   = IDLE;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seg_p2s_tx.sv
// Scoreboard bench for seg_p2s_tx: one instance at DIV=2 and one at DIV=1, with a
// monitor that rebuilds each frame from the serial pins and checks it against the queue.
module tb_seg_p2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start = 2'b00;
    logic [63:0] data0 = '0;
    logic [63:0] data1 = '0;
    logic [1:0]  busy, done, sclk, sdat, spen, sclr;

    always #5 clk = ~clk;

    seg_p2s_tx #(.DIV(2), .NBITS(64)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .data(data0),
        .busy(busy[0]), .done(done[0]), .s_clk(sclk[0]), .s_dat(sdat[0]),
        .s_pen(spen[0]), .s_clr(sclr[0])
    );

    seg_p2s_tx #(.DIV(1), .NBITS(64)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .data(data1),
        .busy(busy[1]), .done(done[1]), .s_clk(sclk[1]), .s_dat(sdat[1]),
        .s_pen(spen[1]), .s_clr(sclr[1])
    );

    typedef struct {
        logic [63:0] frame;
        int          st;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   pen_edge0[$];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: rebuild the frame on each s_clk rise, compare on s_pen rise, time done.
    logic [63:0] model [2];
    int          nb [2];
    int          last_st [2];
    int          pen_cnt [2];
    int          done_cnt [2];
    logic [1:0]  p_sclk = 2'b00;
    logic [1:0]  p_spen = 2'b00;

    initial begin
        for (int i = 0; i < 2; i++) begin
            model[i] = '0; nb[i] = 0; last_st[i] = 0; pen_cnt[i] = 0; done_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        exp_t f;
        bit   has;
        int   d;
        int   rel;
        for (int i = 0; i < 2; i++) begin
            d   = (i == 0) ? 2 : 1;
            has = (i == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
            f.frame = '0;
            f.st    = 0;
            if (has) f = (i == 0) ? sb0[0] : sb1[0];
            rel = edge_cnt - f.st;
            if (rst) begin
                nb[i] = 0;
            end else begin
                if (sclk[i] && !p_sclk[i]) begin
                    chk("frame queued at s_clk rise", 64'(has), 64'd1);
                    if (has) chk("s_clk rise time", 64'(rel), 64'((2 * nb[i] + 1) * d));
                    model[i] = {model[i][62:0], sdat[i]};
                    nb[i]++;
                end
                if (spen[i] && !p_spen[i]) begin
                    pen_cnt[i]++;
                    if (i == 0) pen_edge0.push_back(edge_cnt);
                    chk("frame queued at s_pen rise", 64'(has), 64'd1);
                    if (has) begin
                        chk("frame content", model[i], f.frame);
                        chk("bits per frame", 64'(nb[i]), 64'd64);
                        chk("s_pen rise time", 64'(rel), 64'(128 * d));
                        last_st[i] = f.st;
                        if (i == 0) void'(sb0.pop_front());
                        else        void'(sb1.pop_front());
                    end
                    nb[i] = 0;
                end
                if (done[i]) begin
                    done_cnt[i]++;
                    chk("done time", 64'(edge_cnt - last_st[i]), 64'(129 * d));
                    chk("busy low with done", 64'(busy[i]), 64'd0);
                    chk("s_pen low with done", 64'(spen[i]), 64'd0);
                end
            end
            p_sclk[i] = sclk[i];
            p_spen[i] = spen[i];
        end
    end

    task automatic send(input int i, input logic [63:0] v, output int st);
        @(posedge clk); #1;
        if (i == 0) data0 = v; else data1 = v;
        start[i] = 1'b1;
        st = edge_cnt + 1;
        if (i == 0) sb0.push_back('{v, st}); else sb1.push_back('{v, st});
        @(posedge clk); #1;
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n = 0;
        while (!done[i] && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done within budget", 64'(done[i]), 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, pc, dc;
        int gap;

        // Reset state with the clock running.
        idle_cycles(3);
        chk("reset busy",  64'(busy),  64'd0);
        chk("reset done",  64'(done),  64'd0);
        chk("reset s_clk", 64'(sclk),  64'd0);
        chk("reset s_dat", 64'(sdat),  64'd0);
        chk("reset s_pen", 64'(spen),  64'd0);
        chk("reset s_clr", 64'(sclr),  64'd0);
        rst = 1'b0;
        chk("s_clr before first edge", 64'(sclr), 64'd0);
        idle_cycles(1);
        chk("s_clr after release", 64'(sclr), 64'h3);
        idle_cycles(4);
        chk("s_clr stays high", 64'(sclr), 64'h3);

        // Single frame at DIV=2.
        send(0, 64'h8000_0000_0000_0001, st);
        chk("busy after start", 64'(busy[0]), 64'd1);
        wait_done(0, 300);
        chk("single frame latency", 64'(edge_cnt - st), 64'd258);
        chk("single frame pen count", 64'(pen_cnt[0]), 64'd1);
        idle_cycles(1);
        chk("done is one cycle", 64'(done[0]), 64'd0);
        chk("s_dat low in idle", 64'(sdat[0]), 64'd0);

        // start and data changes while busy are ignored.
        pc = pen_cnt[0];
        dc = done_cnt[0];
        send(0, 64'h0F1E_2D3C_4B5A_6978, st);
        while (edge_cnt < st + 49) begin
            @(posedge clk); #1;
        end
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        data0 = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("busy during frame", 64'(busy[0]), 64'd1);
        wait_done(0, 300);
        idle_cycles(300);
        chk("one done for busy test", 64'(done_cnt[0] - dc), 64'd1);
        chk("one s_pen for busy test", 64'(pen_cnt[0] - pc), 64'd1);
        chk("no second frame", 64'(busy[0]), 64'd0);
        chk("scoreboard empty", 64'(sb0.size()), 64'd0);

        // Back-to-back frames with start held high.
        @(posedge clk); #1;
        data0 = 64'h0123_4567_89AB_CDEF;
        start[0] = 1'b1;
        sb0.push_back('{64'h0123_4567_89AB_CDEF, edge_cnt + 1});
        @(posedge clk); #1;
        wait_done(0, 300);
        data0 = 64'hFEDC_BA98_7654_3210;
        sb0.push_back('{64'hFEDC_BA98_7654_3210, edge_cnt + 1});
        @(posedge clk); #1;
        chk("second frame starts at once", 64'(busy[0]), 64'd1);
        start[0] = 1'b0;
        wait_done(0, 300);
        idle_cycles(2);
        gap = 0;
        if (pen_edge0.size() >= 2) gap = pen_edge0[pen_edge0.size() - 1] - pen_edge0[pen_edge0.size() - 2];
        chk("s_pen spacing back-to-back", 64'(gap), 64'd259);
        chk("scoreboard drained", 64'(sb0.size()), 64'd0);

        // Reset in the middle of a frame.
        send(0, 64'hDEAD_BEEF_0BAD_F00D, st);
        while (edge_cnt < st + 100) begin
            @(posedge clk); #1;
        end
        pc = pen_cnt[0];
        dc = done_cnt[0];
        #2;
        rst = 1'b1;
        #1;
        chk("abort busy",  64'(busy[0]), 64'd0);
        chk("abort s_clk", 64'(sclk[0]), 64'd0);
        chk("abort s_dat", 64'(sdat[0]), 64'd0);
        chk("abort s_pen", 64'(spen[0]), 64'd0);
        chk("abort s_clr", 64'(sclr[0]), 64'd0);
        sb0.delete();
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(300);
        chk("no s_pen for aborted frame", 64'(pen_cnt[0] - pc), 64'd0);
        chk("no done for aborted frame", 64'(done_cnt[0] - dc), 64'd0);
        chk("s_clr high after abort", 64'(sclr[0]), 64'd1);
        send(0, 64'hC0FF_EE00_1234_5678, st);
        wait_done(0, 300);
        chk("frame after abort sent", 64'(pen_cnt[0] - pc), 64'd1);

        // DIV=1: s_clk toggles every cycle, alternating data.
        send(1, 64'hAAAA_AAAA_AAAA_AAAA, st);
        for (int e = 1; e < 128; e++) begin
            @(posedge clk); #1;
            chk("div1 s_clk phase", 64'(sclk[1]), 64'(e % 2));
            chk("div1 s_dat value", 64'(sdat[1]), 64'(((e / 2) % 2) == 0));
        end
        wait_done(1, 10);
        chk("div1 latency", 64'(edge_cnt - st), 64'd129);
        idle_cycles(3);
        chk("div1 frame count", 64'(pen_cnt[1]), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
